prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

Parametrised, run-time loadable instruction memory for the processor core. It replaces the fixed 16×16 program ROM. It has a registered fetch port with a valid flag and a streaming load port, so a host or UART bootloader can write a new program image without resynthesis. It sits between the fetch stage (PC → instruction) and the board-level program source.

## Interface

- DATA_W, 16, instruction width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- fetch_addr  input  ADDR_W  word address from PC
- fetch_req  input  1  fetch request, sampled each cycle
- instruction  output  DATA_W  registered fetch data
- inst_valid  output  1  instruction holds data for the previous cycle's request
- load_start  input  1  single-cycle pulse; begins a full-image load at word 0
- load_valid  input  1  load_data is valid this cycle
- load_data  input  DATA_W  next program word
- load_ready  output  1  block accepts a word this cycle
- loading  output  1  load in progress; the core must stall fetch
- load_done  output  1  one-cycle pulse after the final word is written

## Operation

- Storage is a DEPTH×DATA_W array. Every word initialises to 0 (NOP) at configuration. rst does not clear the contents.
- The FSM has two states: IDLE and LOAD. Reset enters IDLE.
- IDLE:
  - fetch_req=1 registers mem[fetch_addr] into instruction and sets inst_valid=1 on the next cycle.
  - fetch_req=0 clears inst_valid; instruction holds its last value.
  - load_start=1 moves to LOAD and clears wr_ptr (ADDR_W+1 bits) to 0.
- LOAD:
  - loading=1 and load_ready=1.
  - Each cycle with load_valid&&load_ready writes load_data to mem[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr=DEPTH-1 returns the FSM to IDLE and pulses load_done on the next cycle.
- In LOAD, fetch_req is ignored: inst_valid=0 and instruction holds its value.
- In LOAD, load_start is ignored. A load cannot be restarted mid-image.
- In IDLE, load_valid is ignored and nothing is written.
- load_start and fetch_req together in IDLE: the fetch is served from the old contents, then the FSM enters LOAD.
- Reset during LOAD:
  - The FSM returns to IDLE. Words already written are kept; the rest keep their previous contents.
  - load_done is not pulsed.
- Fetch addresses cover the full DEPTH, so there is no out-of-range case. The PC wraps naturally at DEPTH.

## Timing

- Fetch latency is 1 cycle: a request at edge N produces instruction/inst_valid after edge N+1. Throughput is one fetch per cycle.
- load_start at edge N: loading=1 and load_ready=1 from cycle N+1.
- A load takes at least DEPTH accepted cycles. Gaps with load_valid=0 stall wr_ptr.
- Final write at edge M: loading=0, load_ready=0 and load_done=1 in cycle M+1. load_done=0 in cycle M+2. The first fetch is possible at M+1, returning data at M+2.
- Reset values: instruction=0, inst_valid=0, load_ready=0, loading=0, load_done=0, wr_ptr=0, state=IDLE.
- No combinational path from inputs to outputs.

## Configuration

- PROG_MEM_LOAD_EN defined: the load FSM, write port and load outputs are built as described above.
- PROG_MEM_LOAD_EN undefined:
  - The memory is read-only and its contents are the initial image.
  - load_start, load_valid and load_data are ignored.
  - load_ready, loading and load_done are tied to 0.
  - Fetch behaviour and timing are unchanged.
- Ports are identical in both builds.

## Test plan

- Reset, then fetch address 5 → instruction=16'h0000 with inst_valid=1 one cycle later. All outputs are 0 during and after rst.
- Pulse load_start, stream the words 16'h1000+i for i=0..15 back-to-back → loading=1 for 16 cycles, then load_done pulses once. Fetch addresses 0..15 → 16'h1000..16'h100F, each with 1-cycle latency.
- Load with load_valid toggling every other cycle → exactly 16 writes, load_done after the 16th accepted word, contents correct.
- During LOAD, assert fetch_req at address 3 → inst_valid stays 0. A second load_start mid-load is ignored and wr_ptr continues.
- Assert rst after 6 words of a load of 16'hA000+i → loading=0 and no load_done. Fetch 0..5 → 16'hA000..16'hA005; fetch 6..15 → prior contents.
- Build without PROG_MEM_LOAD_EN, pulse load_start and stream 16 words → load_ready stays 0 and fetches return the initial image unchanged.

Source files
------------

// File: rtl/prog_mem_loader_if.sv
// Fetch and load port bundle for the run-time loadable program memory.
// master drives requests and load words; slave is the memory side.
interface prog_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              loading;
  logic              load_done;

  modport master (
    output fetch_addr, fetch_req,
    output load_start, load_valid, load_data,
    input  instruction, inst_valid,
    input  load_ready, loading, load_done
  );

  modport slave (
    input  fetch_addr, fetch_req,
    input  load_start, load_valid, load_data,
    output instruction, inst_valid,
    output load_ready, loading, load_done
  );
endinterface

// File: rtl/prog_mem_loader.sv
// Loadable instruction memory: registered fetch port plus streaming image load.
// The load FSM and write port are built only when PROG_MEM_LOAD_EN is defined.
module prog_mem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic              clk,
  input logic              rst,
  prog_mem_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Contents power up as NOPs; rst deliberately leaves them alone.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic fetch_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instruction <= '0;
      bus.inst_valid  <= 1'b0;
    end else begin
      bus.inst_valid <= fetch_en;
      if (fetch_en) begin
        bus.instruction <= mem[bus.fetch_addr];
      end
    end
  end

`ifdef PROG_MEM_LOAD_EN
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_t          state;
  state_t          state_nx;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] wr_ptr_nx;
  logic            done_nx;
  logic            wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      bus.load_done <= 1'b0;
    end else begin
      state         <= state_nx;
      wr_ptr        <= wr_ptr_nx;
      bus.load_done <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_ptr_nx = wr_ptr;
    done_nx   = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nx  = LOAD;
          wr_ptr_nx = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          wr_en     = 1'b1;
          wr_ptr_nx = wr_ptr + 1'b1;
          if (wr_ptr == LAST) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
    endcase
  end

  // A word arriving in the same cycle as rst is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  assign fetch_en       = bus.fetch_req && (state == IDLE);
  assign bus.loading    = (state == LOAD);
  assign bus.load_ready = (state == LOAD);
`else
  logic unused_load;

  assign unused_load    = ^{bus.load_start, bus.load_valid, bus.load_data};
  assign fetch_en       = bus.fetch_req;
  assign bus.loading    = 1'b0;
  assign bus.load_ready = 1'b0;
  assign bus.load_done  = 1'b0;
`endif
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader; expectations follow the build's
// PROG_MEM_LOAD_EN setting so the same vectors cover both variants.
module tb_prog_mem_loader;
`ifdef PROG_MEM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_mem_loader_if bus ();

  prog_mem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;
  int done_cnt = 0;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && bus.inst_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_valid: got instr %h expected no valid at %0t",
                 bus.instruction, $time);
      end else begin
        e = exp_q.pop_front();
        check("fetch_data", {16'h0, bus.instruction}, {16'h0, e});
      end
    end
    if (bus.load_done) done_cnt++;
  end

  task automatic check_idle_outs(input string name);
    check({name, "_loading"}, bus.loading, 0);
    check({name, "_ready"}, bus.load_ready, 0);
    check({name, "_done"}, bus.load_done, 0);
  endtask

  task automatic fetch_all();
    for (int a = 0; a < 16; a++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 4'(a);
      exp_q.push_back(model[a]);
      cyc();
    end
    bus.fetch_req = 1'b0;
    cyc();
    cyc();
    check("fetch_drain", exp_q.size(), 0);
  endtask

  task automatic run_load(input logic [15:0] base, input bit gap,
                          input bit mid, input int n_words,
                          input bit co_fetch);
    bus.load_start = 1'b1;
    if (co_fetch) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 4'd7;
      exp_q.push_back(model[7]);
    end
    cyc();
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    check("load_loading_on", bus.loading, LOAD_EN);
    check("load_ready_on", bus.load_ready, LOAD_EN);
    for (int i = 0; i < n_words; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = base + 16'(i);
      if (mid && i == 4) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 4'd3;
        if (!LOAD_EN) exp_q.push_back(model[3]);
      end
      if (mid && i == 8) bus.load_start = 1'b1;
      cyc();
      bus.fetch_req  = 1'b0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      if (LOAD_EN) model[i] = base + 16'(i);
      if (i == 15) begin
        check("final_loading", bus.loading, 0);
        check("final_ready", bus.load_ready, 0);
        check("final_done", bus.load_done, LOAD_EN);
      end else begin
        check("mid_loading", bus.loading, LOAD_EN);
        check("mid_done", bus.load_done, 0);
        if (gap) begin
          cyc();
          check("gap_loading", bus.loading, LOAD_EN);
        end
      end
    end
    if (n_words == 16) begin
      cyc();
      check("done_cleared", bus.load_done, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    bus.fetch_addr = '0;
    bus.fetch_req  = 1'b0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    cyc();
    cyc();
    check("rst_instr", {16'h0, bus.instruction}, 0);
    check("rst_valid", bus.inst_valid, 0);
    check_idle_outs("rst");
    rst = 1'b0;
    cyc();
    check("post_rst_valid", bus.inst_valid, 0);
    check_idle_outs("post_rst");

    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd5;
    exp_q.push_back(16'h0000);
    cyc();
    bus.fetch_req = 1'b0;
    cyc();
    check("fetch5_drain", exp_q.size(), 0);

    // Streaming words while idle must not land anywhere.
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hDEAD;
    cyc();
    cyc();
    bus.load_valid = 1'b0;
    check_idle_outs("idle_valid");

    run_load(16'h1000, 1'b0, 1'b0, 16, 1'b0);
    fetch_all();

    run_load(16'h2000, 1'b1, 1'b0, 16, 1'b1);
    fetch_all();

    run_load(16'h3000, 1'b0, 1'b1, 16, 1'b0);
    fetch_all();

    run_load(16'hA000, 1'b0, 1'b0, 6, 1'b0);
    rst = 1'b1;
    cyc();
    check_idle_outs("abort_rst");
    rst = 1'b0;
    cyc();
    check_idle_outs("abort_after");
    cyc();
    check("abort_no_done", bus.load_done, 0);
    fetch_all();

    check("done_pulses", done_cnt, LOAD_EN ? 3 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
